// File: rtl/bp_pkg.sv
// Shared encodings for the 2-bit branch predictor: counter states, FSM states, init value.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [1:0] CTR_RESET = WNT;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-value logic of a 2-bit saturating up/down counter (up on taken).
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] i_cur,
  input  logic       i_taken,
  output logic [1:0] o_next
);

  always_comb begin
    o_next = i_cur;
    if (i_taken) begin
      if (i_cur != ST) o_next = i_cur + 2'd1;
    end else begin
      if (i_cur != SNT) o_next = i_cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Untagged bimodal branch predictor with a power-up sweep that initialises every entry.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic            ready,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_pred,
  output logic            mispredict
`ifdef BP_STATS_EN
  ,
  input  logic            stats_clr,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mis_cnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]       r_table [ENTRIES];
  logic [IDX_W-1:0] r_idx;
  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_ready;
  logic             w_init_wr;
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_up_idx;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_nxt;
  logic             w_upd_acc;
  logic             w_mis_cond;
  logic             r_mis;
  logic             w_unused;

  assign w_lk_idx   = lookup_pc[IDX_W+1:2];
  assign w_up_idx   = upd_pc[IDX_W+1:2];
  assign w_unused   = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                        upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

  assign w_upd_acc  = upd_valid & w_ready;
  assign w_mis_cond = w_upd_acc & (upd_taken != upd_pred);
  assign w_ctr_cur  = r_table[w_up_idx];

  bp_sat_ctr u_sat_ctr (
    .i_cur   (w_ctr_cur),
    .i_taken (upd_taken),
    .o_next  (w_ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_init_wr   = 1'b0;
    case (r_state)
      INIT: begin
        w_init_wr = 1'b1;
        if (r_idx == IDX_W'(ENTRIES - 1)) w_state_nxt = READY;
      end
      READY: begin
        w_ready = 1'b1;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_idx <= '0;
    else if (w_init_wr) r_idx <= r_idx + IDX_W'(1);
  end

  // Table has no reset: its contents are established only by the INIT sweep.
  // The read port sees the old value, so a same-index lookup returns pre-update data.
  always_ff @(posedge clk) begin
    if (w_init_wr)      r_table[r_idx]    <= CTR_RESET;
    else if (w_upd_acc) r_table[w_up_idx] <= w_ctr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mis <= 1'b0;
    else        r_mis <= w_mis_cond;
  end

  assign ready      = w_ready;
  assign pred_taken = w_ready & r_table[w_lk_idx][1];
  assign mispredict = r_mis;

`ifdef BP_STATS_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;

  // Clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (stats_clr) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_upd_acc)  r_br_cnt  <= r_br_cnt + 32'd1;
      if (w_mis_cond) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign br_cnt  = r_br_cnt;
  assign mis_cnt = r_mis_cnt;
`endif

endmodule
